// File: rtl/rib_dma_pkg.sv
// Shared types and constants for the rib_dma word-copy engine.
package rib_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } dma_state_e;

    // Register offsets, decoded from s_addr_i[3:2]
    localparam logic [1:0] DMA_SRC  = 2'd0;
    localparam logic [1:0] DMA_DST  = 2'd1;
    localparam logic [1:0] DMA_LEN  = 2'd2;
    localparam logic [1:0] DMA_CTRL = 2'd3;

    // CTRL write bits; the same positions read back as BUSY/DONE/ABORTED/IE
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_ABORT = 2;
    localparam int CTRL_IE    = 3;

endpackage

// File: rtl/rib_dma_if.sv
// Bus bundle for rib_dma: config slave port, m1 master port and interrupt.
// The slave modport is the DMA's view; master is the view of the fabric/CPU side.
interface rib_dma_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] s_addr_i;
    logic [DATA_W-1:0] s_data_i;
    logic [DATA_W-1:0] s_data_o;
    logic              s_we_i;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_o;
    logic [DATA_W-1:0] m_data_i;
    logic              m_req_o;
    logic              m_we_o;
    logic              m_gnt_i;
    logic              irq_o;

    modport slave (
        input  s_addr_i, s_data_i, s_we_i, m_data_i, m_gnt_i,
        output s_data_o, m_addr_o, m_data_o, m_req_o, m_we_o, irq_o
    );

    modport master (
        output s_addr_i, s_data_i, s_we_i, m_data_i, m_gnt_i,
        input  s_data_o, m_addr_o, m_data_o, m_req_o, m_we_o, irq_o
    );
endinterface

// File: rtl/rib_dma_regs.sv
// Config register file: SRC/DST/LEN, CTRL/STAT flags with W1C DONE, read mux, irq.
module rib_dma_regs
    import rib_dma_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              busy,
    input  logic              done_set,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] src,
    output logic [DATA_W-1:0] dst,
    output logic [DATA_W-1:0] len,
    output logic              start_go,
    output logic              abort_req,
    output logic              irq
);
    logic done, aborted, ie;
    logic done_n, aborted_n, ie_n;
    logic wr_ctrl, start_acc, start_zero;

    // A START that also carries ABORT is dropped; ABORT only acts on a running copy
    assign wr_ctrl    = we && (addr == DMA_CTRL);
    assign start_acc  = wr_ctrl && wdata[CTRL_START] && !wdata[CTRL_ABORT] && !busy;
    assign start_go   = start_acc && (len != '0);
    assign start_zero = start_acc && (len == '0);
    assign abort_req  = wr_ctrl && wdata[CTRL_ABORT];

    // Flag next-state: clears first, sets last so a set beats a same-cycle W1C
    always_comb begin
        done_n    = done;
        aborted_n = aborted;
        ie_n      = ie;
        if (wr_ctrl) ie_n = wdata[CTRL_IE];
        if (start_acc) begin
            done_n    = 1'b0;
            aborted_n = 1'b0;
        end
        if (wr_ctrl && wdata[CTRL_DONE]) done_n = 1'b0;
        if (done_set || start_zero) done_n = 1'b1;
        if (abort_req && busy) aborted_n = 1'b1;
    end

    // Register storage; pointer and length writes are locked out while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            ie      <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (we && !busy) begin
                case (addr)
                    DMA_SRC: src <= {wdata[DATA_W-1:2], 2'b00};
                    DMA_DST: dst <= {wdata[DATA_W-1:2], 2'b00};
                    DMA_LEN: len <= wdata;
                    default: ;
                endcase
            end
            done    <= done_n;
            aborted <= aborted_n;
            ie      <= ie_n;
            irq     <= done_n & ie_n;
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata = '0;
        case (addr)
            DMA_SRC: rdata = src;
            DMA_DST: rdata = dst;
            DMA_LEN: rdata = len;
            default: begin
                rdata[CTRL_START] = busy;
                rdata[CTRL_DONE]  = done;
                rdata[CTRL_ABORT] = aborted;
                rdata[CTRL_IE]    = ie;
            end
        endcase
    end
endmodule

// File: rtl/rib_dma.sv
// Single-channel word-copy DMA: read/write FSM and working-copy datapath.
//
// state | meaning
// IDLE  | no transfer; master port driven to zero
// RD    | requesting a read at cur_src
// WR    | requesting a write of rd_buf at cur_dst
module rib_dma #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    rib_dma_if.slave bus
);
    import rib_dma_pkg::*;

    dma_state_e        state, state_n;
    logic [ADDR_W-1:0] cur_src, cur_dst;
    logic [DATA_W-1:0] cnt, rd_buf;
    logic [DATA_W-1:0] src, dst, len;
    logic              start_go, abort_req, done_set, busy;
    logic              unused_addr;

    assign busy        = (state != IDLE);
    assign unused_addr = ^{bus.s_addr_i[ADDR_W-1:4], bus.s_addr_i[1:0]};

    rib_dma_regs #(.DATA_W(DATA_W)) u_regs (
        .clk       (clk),
        .rst       (rst),
        .addr      (bus.s_addr_i[3:2]),
        .wdata     (bus.s_data_i),
        .we        (bus.s_we_i),
        .busy      (busy),
        .done_set  (done_set),
        .rdata     (bus.s_data_o),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .start_go  (start_go),
        .abort_req (abort_req),
        .irq       (bus.irq_o)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and master outputs; outputs depend only on registers so a stall holds them
    always_comb begin
        state_n      = state;
        done_set     = 1'b0;
        bus.m_req_o  = 1'b0;
        bus.m_we_o   = 1'b0;
        bus.m_addr_o = '0;
        bus.m_data_o = '0;
        case (state)
            IDLE: if (start_go) state_n = RD;
            RD: begin
                bus.m_req_o  = 1'b1;
                bus.m_addr_o = cur_src;
                if (abort_req)          state_n = IDLE;
                else if (bus.m_gnt_i)   state_n = WR;
            end
            WR: begin
                bus.m_req_o  = 1'b1;
                bus.m_we_o   = 1'b1;
                bus.m_addr_o = cur_dst;
                bus.m_data_o = rd_buf;
                if (abort_req) begin
                    state_n = IDLE;
                end else if (bus.m_gnt_i) begin
                    if (cnt == DATA_W'(1)) begin
                        state_n  = IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Working copies; the programmed registers are never touched by a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_src <= '0;
            cur_dst <= '0;
            cnt     <= '0;
            rd_buf  <= '0;
        end else begin
            case (state)
                IDLE: if (start_go) begin
                    cur_src <= ADDR_W'(src);
                    cur_dst <= ADDR_W'(dst);
                    cnt     <= len;
                end
                RD: if (bus.m_gnt_i && !abort_req) begin
                    rd_buf  <= bus.m_data_i;
                    cur_src <= cur_src + ADDR_W'(4);
                end
                WR: if (bus.m_gnt_i && !abort_req) begin
                    cur_dst <= cur_dst + ADDR_W'(4);
                    cnt     <= cnt - DATA_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rib_dma.md
# rib_dma

Single-channel word-copy DMA engine for the RIB interconnect. It is configured by the CPU through a RIB slave port (mapped on the slave-5 window, `0x5xxx_xxxx`). It then moves data as a RIB master on port m1, copying LEN 32-bit words from SRC to DST with one read and one write per word. It frees the CPU from memcpy loops between RAM and peripherals and raises a level interrupt on completion.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width.
- `DATA_W`, 32: bus data width (the block supports word transfers only).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_addr_i`  in  32  config slave address; only bits [3:2] are decoded.
- `s_data_i`  in  32  config write data.
- `s_data_o`  out  32  config read data, combinational from `s_addr_i[3:2]`.
- `s_we_i`  in  1  config write strobe, sampled at `clk`.
- `m_addr_o`  out  32  master address.
- `m_data_o`  out  32  master write data.
- `m_data_i`  in  32  master read data, valid in the same cycle as a granted read.
- `m_req_o`  out  1  master request.
- `m_we_o`  out  1  master write enable.
- `m_gnt_i`  in  1  grant; top level drives `m1_req & ~m0_req`.
- `irq_o`  out  1  completion interrupt (level).

## Operation
Register map, by offset `s_addr_i[3:2]`:
- 0 `SRC`: source pointer. Bits [1:0] are forced to 0 on write.
- 1 `DST`: destination pointer. Bits [1:0] are forced to 0 on write.
- 2 `LEN`: word count, 32-bit.
- 3 `CTRL/STAT`:
  - Write bit0 = START, bit1 = W1C DONE, bit2 = ABORT, bit3 = IE (stored).
  - Read bit0 = BUSY, bit1 = DONE, bit2 = ABORTED, bit3 = IE.

Config write rules:
- Writes to SRC, DST or LEN while BUSY are ignored.
- START while BUSY is ignored.
- START clears DONE and ABORTED.
- START with LEN = 0 sets DONE the next cycle; no bus traffic is generated.

State machine `IDLE`, `RD`, `WR`:
- `IDLE` → `RD` on START with LEN ≠ 0. On this transition, latch the working copies `cur_src`, `cur_dst` and `cnt`.
- `RD`:
  - Drive `m_req_o=1`, `m_we_o=0`, `m_addr_o=cur_src`.
  - On `m_gnt_i`: capture `m_data_i` into `buf`, advance `cur_src` by 4, go to `WR`.
  - Without grant: hold all outputs stable.
- `WR`:
  - Drive `m_req_o=1`, `m_we_o=1`, `m_addr_o=cur_dst`, `m_data_o=buf`.
  - On `m_gnt_i`: advance `cur_dst` by 4 and decrement `cnt`.
  - If `cnt` was 1, go to `IDLE` and set DONE; otherwise go to `RD`.
- ABORT in `RD`/`WR` → `IDLE` next edge. It sets ABORTED, not DONE; a pending unacknowledged beat is dropped.

Boundary and precedence rules:
- Pointer arithmetic wraps modulo 2^32.
- SRC, DST and LEN registers are not modified by a transfer; only the working copies change.
- DONE set and W1C DONE in the same cycle: set wins.
- START and ABORT in the same write: ABORT wins.
- `irq_o = DONE & IE`, registered.
- Outside `RD`/`WR`: `m_req_o=0`, `m_we_o=0`, `m_addr_o=0`, `m_data_o=0`.

## Timing
- Reset clears all registers and working copies, and forces state `IDLE`.
- Reset values of outputs:
  - `m_req_o`, `m_we_o`, `irq_o` = 0.
  - `m_addr_o`, `m_data_o` = 0.
  - `s_data_o` follows register contents, which are all 0.
- Reset mid-transfer aborts immediately; no flag is set.
- START written at edge T: BUSY=1 and `m_req_o=1` (RD) from T+1.
- Each word takes exactly 2 granted cycles. With continuous grant, an N-word copy issues its last write in cycle T+2N.
- DONE and `irq_o` are visible at T+2N+1; BUSY falls at the same edge.
- Grant loss stalls the FSM with outputs unchanged; there is no timeout.
- Config reads are combinational and have zero latency.

## Structure
- `rib_dma_pkg`:
  - State enum `dma_state_e` (`IDLE`, `RD`, `WR`).
  - Register offset constants `DMA_SRC=2'd0`, `DMA_DST=2'd1`, `DMA_LEN=2'd2`, `DMA_CTRL=2'd3`.
  - CTRL bit-index constants `CTRL_START=0`, `CTRL_DONE=1`, `CTRL_ABORT=2`, `CTRL_IE=3`.
- One natural sub-module: `rib_dma_regs`, holding the register file, W1C logic, read mux and irq. The FSM and datapath stay in `rib_dma`.

## Test plan
- SRC=0x0000_0100, DST=0x0000_0200, LEN=4, grant always 1:
  - Words at 0x100..0x10C appear at 0x200..0x20C.
  - 8 request cycles alternating we=0/1.
  - DONE and `irq_o` (IE=1) at T+9.
- Same 4-word copy with `m_gnt_i` low for 3 cycles during a WR:
  - `m_addr_o`, `m_data_o` and `m_we_o` stay stable throughout the stall.
  - Data is correct and completion is delayed by exactly 3 cycles.
- LEN=0 START → DONE at T+1, `m_req_o` never asserted.
- ABORT after 1 word of LEN=8:
  - ABORTED=1, DONE=0.
  - Only DST word 0 is written.
  - Writes to SRC while BUSY earlier were ignored (read back unchanged).
- SRC=0xFFFF_FFFC, LEN=2 → the second read is at 0x0000_0000 (wrap).
- Write SRC=0x103 → it reads back as 0x100.
- W1C DONE in the same cycle DONE is set → DONE reads 1.
